// File: rtl/search_pkg.sv
// Shared types and helpers for the NLFSR search-array result path.
// Holds the frame header byte, serialiser state type and sizing functions.
package search_pkg;

    localparam logic [7:0] FRAME_HDR = 8'hA5;

    typedef enum logic [1:0] {
        IDLE,
        HDR,
        IDX,
        DATA
    } ser_state_t;

    function automatic int clog2(input int v);
        int r;
        int x;
        r = 0;
        x = 1;
        while (x < v) begin
            x = x * 2;
            r++;
        end
        return r;
    endfunction

    // Bytes needed to carry a coefficient word, rounded up.
    function automatic int coef_bytes(input int w);
        return (w + 7) / 8;
    endfunction

endpackage

// File: rtl/sync_fifo.sv
// Synchronous FIFO with a registered read port (dout updates on pop).
// Ports: clk, res (sync active-low), push/din, pop/dout, full, empty.
module sync_fifo
    import search_pkg::*;
#(
    parameter int WIDTH = 8,
    parameter int DEPTH = 8
) (
    input  logic             clk,
    input  logic             res,
    input  logic             push,
    input  logic             pop,
    input  logic [WIDTH-1:0] din,
    output logic [WIDTH-1:0] dout,
    output logic             full,
    output logic             empty
);

    localparam int AW = (DEPTH > 1) ? clog2(DEPTH) : 1;

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic [AW:0]      count;
    logic             do_pop;
    logic             do_push;

    assign full    = (count == (AW+1)'(DEPTH));
    assign empty   = (count == '0);
    assign do_pop  = pop && !empty;
    // A pop in the same cycle frees the slot, so a push into a full FIFO lands.
    assign do_push = push && (!full || do_pop);

    always_ff @(posedge clk) begin
        if (!res) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
            dout   <= '0;
        end else begin
            if (do_push) begin
                wr_ptr <= wr_ptr + AW'(1);
            end
            if (do_pop) begin
                dout   <= mem[rd_ptr];
                rd_ptr <= rd_ptr + AW'(1);
            end
            unique case ({do_push, do_pop})
                2'b10:   count <= count + (AW+1)'(1);
                2'b01:   count <= count - (AW+1)'(1);
                default: count <= count;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (do_push) begin
            mem[wr_ptr] <= din;
        end
    end

endmodule

// File: rtl/search_array_collector.sv
// Round-robin result collector for the search engines, with framed byte output.
// Ports: eng_found/eng_failure/eng_coef in, eng_restart out, tx_* byte stream,
//        found_any, found_cnt, fail_cnt, fifo_full status; clk, res (sync, low).
module search_array_collector
    import search_pkg::*;
#(
    parameter int NUM_ENG = 30,
    parameter int COEF_W  = 40,
    parameter int DEPTH   = 8,
    parameter int CNT_W   = 16
) (
    input  logic                      clk,
    input  logic                      res,
    input  logic                      enable,
    input  logic [NUM_ENG-1:0]        eng_found,
    input  logic [NUM_ENG-1:0]        eng_failure,
    input  logic [NUM_ENG*COEF_W-1:0] eng_coef,
    output logic [NUM_ENG-1:0]        eng_restart,
    output logic [7:0]                tx_data,
    output logic                      tx_valid,
    input  logic                      tx_ready,
    output logic                      found_any,
    output logic [CNT_W-1:0]          found_cnt,
    output logic [CNT_W-1:0]          fail_cnt,
    output logic                      fifo_full
);

    localparam int IW = (NUM_ENG > 1) ? clog2(NUM_ENG) : 1;
    localparam int CB = coef_bytes(COEF_W);
    localparam int SW = CB * 8;
    localparam int FW = 8 + COEF_W;
    localparam int BW = (CB > 1) ? clog2(CB) : 1;

    logic [NUM_ENG-1:0] mask;
    logic [NUM_ENG-1:0] elig;
    logic [IW-1:0]      rr_ptr;
    logic [IW-1:0]      rr_nxt;
    logic [IW-1:0]      gnt_idx;
    logic               gnt_vld;
    logic               gnt_found;
    logic [COEF_W-1:0]  gnt_coef;

    logic               push;
    logic               pop;
    logic               fifo_empty;
    logic [FW-1:0]      fifo_din;
    logic [FW-1:0]      fifo_dout;

    ser_state_t         state;
    logic [SW-1:0]      shreg;
    logic [BW-1:0]      bcnt;
    logic               last_byte;

    // A found engine stays pending while the FIFO is full; failures still go.
    assign elig = ~mask
                & (eng_found | eng_failure)
                & ~(eng_found & {NUM_ENG{fifo_full}})
                & {NUM_ENG{enable}};

    // First eligible index at or after rr_ptr, wrapping.
    always_comb begin
        int j;
        j       = 0;
        gnt_vld = 1'b0;
        gnt_idx = '0;
        for (int k = 0; k < NUM_ENG; k++) begin
            j = int'(rr_ptr) + k;
            if (j >= NUM_ENG) begin
                j = j - NUM_ENG;
            end
            if (!gnt_vld && elig[j]) begin
                gnt_vld = 1'b1;
                gnt_idx = IW'(j);
            end
        end
    end

    assign gnt_found = eng_found[gnt_idx];
    assign gnt_coef  = eng_coef[int'(gnt_idx)*COEF_W +: COEF_W];
    assign rr_nxt    = (gnt_idx == IW'(NUM_ENG-1)) ? '0 : gnt_idx + IW'(1);
    assign push      = gnt_vld && gnt_found;
    assign fifo_din  = {8'(gnt_idx), gnt_coef};

    always_ff @(posedge clk) begin
        if (!res) begin
            mask        <= '0;
            rr_ptr      <= '0;
            eng_restart <= '0;
            found_any   <= 1'b0;
            found_cnt   <= '0;
            fail_cnt    <= '0;
        end else begin
            eng_restart <= '0;
            // Unmask once both flags are seen low.
            mask <= mask & (eng_found | eng_failure);
            if (gnt_vld) begin
                eng_restart[gnt_idx] <= 1'b1;
                mask[gnt_idx]        <= 1'b1;
                rr_ptr               <= rr_nxt;
                if (gnt_found) begin
                    found_any <= 1'b1;
                    if (found_cnt != '1) begin
                        found_cnt <= found_cnt + CNT_W'(1);
                    end
                end else if (fail_cnt != '1) begin
                    fail_cnt <= fail_cnt + CNT_W'(1);
                end
            end
        end
    end

    sync_fifo #(
        .WIDTH (FW),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk   (clk),
        .res   (res),
        .push  (push),
        .pop   (pop),
        .din   (fifo_din),
        .dout  (fifo_dout),
        .full  (fifo_full),
        .empty (fifo_empty)
    );

    assign last_byte = (bcnt == BW'(CB-1));

    // Pop when starting a frame from idle, or chaining straight into the next.
    assign pop = !fifo_empty
              && ((state == IDLE)
               || (state == DATA && tx_ready && last_byte));

    always_ff @(posedge clk) begin
        if (!res) begin
            state    <= IDLE;
            tx_valid <= 1'b0;
            tx_data  <= '0;
            shreg    <= '0;
            bcnt     <= '0;
        end else begin
            unique case (state)
                IDLE: begin
                    if (!fifo_empty) begin
                        state    <= HDR;
                        tx_valid <= 1'b1;
                        tx_data  <= FRAME_HDR;
                    end
                end
                HDR: begin
                    if (tx_ready) begin
                        state   <= IDX;
                        tx_data <= fifo_dout[FW-1 -: 8];
                        shreg   <= SW'(fifo_dout[COEF_W-1:0]);
                    end
                end
                IDX: begin
                    if (tx_ready) begin
                        state   <= DATA;
                        tx_data <= shreg[SW-1 -: 8];
                        shreg   <= shreg << 8;
                        bcnt    <= '0;
                    end
                end
                DATA: begin
                    if (tx_ready) begin
                        if (last_byte) begin
                            if (!fifo_empty) begin
                                state   <= HDR;
                                tx_data <= FRAME_HDR;
                            end else begin
                                state    <= IDLE;
                                tx_valid <= 1'b0;
                                tx_data  <= '0;
                            end
                        end else begin
                            tx_data <= shreg[SW-1 -: 8];
                            shreg   <= shreg << 8;
                            bcnt    <= bcnt + BW'(1);
                        end
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule
